// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: word and RAM handshake encodings plus the arbiter's own state/op types.
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_D = 2'd1,
    SERVE_I = 2'd2
  } arb_state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } arb_op_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of data grants taken while a fetch was waiting.
module arb_starve_ctr #(
  parameter  int unsigned STARVE_MAX = 4,
  localparam int unsigned CW         = $clog2(STARVE_MAX + 1)
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] count
);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != CW'(STARVE_MAX))) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-master RAM arbiter between icache fetches and dcache reads/writes; data side has priority.
// Define ARB_FAIR_EN to bound fetch starvation to STARVE_MAX consecutive data grants.
module mem_arbiter
  import cpu_types_pkg::*;
`ifdef ARB_FAIR_EN
#(
  parameter int unsigned STARVE_MAX = 4
)
`endif
(
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate
);

  arb_state_t state_q, state_d;
  arb_op_t    op_q, op_d;
  word_t      addr_q, addr_d;
  word_t      store_q, store_d;
  logic       dreq;
  logic       forced;

  assign dreq = dREN | dWEN;

`ifdef ARB_FAIR_EN
  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starve_count;
  logic          starve_inc;
  logic          starve_clr;

  assign starve_inc = (state_q == IDLE) && (state_d == SERVE_D) && iREN;
  assign starve_clr = (state_q == IDLE) && (!iREN || (state_d == SERVE_I));
  assign forced     = iREN && (starve_count == CW'(STARVE_MAX));

  arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve_ctr (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (starve_inc),
    .clr  (starve_clr),
    .count(starve_count)
  );
`else
  assign forced = 1'b0;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      op_q    <= OP_RD;
      addr_q  <= '0;
      store_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      store_q <= store_d;
    end
  end

  // A dropped request or an ERROR both just return to IDLE; the requester re-arbitrates from scratch.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    store_d = store_q;
    unique case (state_q)
      IDLE: begin
        if (dreq && !forced) begin
          state_d = SERVE_D;
          op_d    = dWEN ? OP_WR : OP_RD;
          addr_d  = daddr;
          store_d = dstore;
        end else if (iREN) begin
          state_d = SERVE_I;
          op_d    = OP_RD;
          addr_d  = iaddr;
          store_d = '0;
        end
      end
      SERVE_D: begin
        if (!dreq || (ramstate == ACCESS) || (ramstate == ERROR)) begin
          state_d = IDLE;
        end
      end
      SERVE_I: begin
        if (!iREN || (ramstate == ACCESS) || (ramstate == ERROR)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ramaddr  = addr_q;
  assign ramstore = store_q;

  always_comb begin
    ramREN = 1'b0;
    ramWEN = 1'b0;
    iwait  = 1'b1;
    dwait  = 1'b1;
    iload  = '0;
    dload  = '0;
    unique case (state_q)
      SERVE_D: begin
        ramREN = (op_q == OP_RD);
        ramWEN = (op_q == OP_WR);
        if (dreq && (ramstate == ACCESS)) begin
          dwait = 1'b0;
          if (op_q == OP_RD) begin
            dload = ramload;
          end
        end
      end
      SERVE_I: begin
        ramREN = 1'b1;
        if (iREN && (ramstate == ACCESS)) begin
          iwait = 1'b0;
          iload = ramload;
        end
      end
      default: begin
        ramREN = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, fetch/data ordering, RAM stalls/errors, dropped requests, fairness.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic      CLK;
  logic      nRST;
  logic      iREN;
  word_t     iaddr;
  logic      iwait;
  word_t     iload;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      dwait;
  word_t     dload;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter dut (
    .CLK     (CLK),
    .nRST    (nRST),
    .iREN    (iREN),
    .iaddr   (iaddr),
    .iwait   (iwait),
    .iload   (iload),
    .dREN    (dREN),
    .dWEN    (dWEN),
    .daddr   (daddr),
    .dstore  (dstore),
    .dwait   (dwait),
    .dload   (dload),
    .ramREN  (ramREN),
    .ramWEN  (ramWEN),
    .ramaddr (ramaddr),
    .ramstore(ramstore),
    .ramload (ramload),
    .ramstate(ramstate)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here, outputs checked 1 later.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  int          comps;
  int          fetches;
  logic [7:0]  pat;

  initial begin
    nRST     = 1'b0;
    iREN     = 1'b0;
    iaddr    = '0;
    dREN     = 1'b0;
    dWEN     = 1'b0;
    daddr    = '0;
    dstore   = '0;
    ramload  = '0;
    ramstate = FREE;

    #2;
    check("rst_ramREN",   ramREN,   0);
    check("rst_ramWEN",   ramWEN,   0);
    check("rst_ramaddr",  ramaddr,  0);
    check("rst_ramstore", ramstore, 0);
    check("rst_iwait",    iwait,    1);
    check("rst_dwait",    dwait,    1);
    check("rst_iload",    iload,    0);
    check("rst_dload",    dload,    0);
    step();
    nRST = 1'b1;

    // Single fetch, RAM ready on first serve cycle
    step();
    iREN = 1'b1; iaddr = 32'h40;
    #1;
    check("t2_c1_ramREN", ramREN, 0);
    check("t2_c1_iwait",  iwait,  1);
    step();
    ramstate = ACCESS; ramload = 32'h8C010004;
    #1;
    check("t2_c2_ramREN",  ramREN,  1);
    check("t2_c2_ramaddr", ramaddr, 32'h40);
    check("t2_c2_iwait",   iwait,   0);
    check("t2_c2_iload",   iload,   32'h8C010004);
    step();
    iREN = 1'b0; ramstate = FREE;
    #1;
    check("t2_idle_ramREN", ramREN, 0);

    // Live address change during SERVE_I is ignored
    step();
    iREN = 1'b1; iaddr = 32'h40;
    step();
    iaddr = 32'h80; ramstate = BUSY;
    #1;
    check("t6_busy_ramaddr", ramaddr, 32'h40);
    check("t6_busy_iwait",   iwait,   1);
    step();
    ramstate = ACCESS; ramload = 32'h11112222;
    #1;
    check("t6_acc_ramaddr", ramaddr, 32'h40);
    check("t6_acc_iwait",   iwait,   0);
    check("t6_acc_iload",   iload,   32'h11112222);
    step();
    iREN = 1'b0; ramstate = FREE;
    #1;
    check("t6_idle_ramREN", ramREN, 0);

    // Fetch and write together: write first, IDLE gap, then fetch
    step();
    iREN = 1'b1; iaddr = 32'h200;
    dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEADBEEF;
    #1;
    check("t3_c1_ramWEN", ramWEN, 0);
    check("t3_c1_iwait",  iwait,  1);
    step();
    ramstate = ACCESS;
    #1;
    check("t3_wr_ramWEN",   ramWEN,   1);
    check("t3_wr_ramREN",   ramREN,   0);
    check("t3_wr_ramaddr",  ramaddr,  32'h100);
    check("t3_wr_ramstore", ramstore, 32'hDEADBEEF);
    check("t3_wr_dwait",    dwait,    0);
    check("t3_wr_iwait",    iwait,    1);
    step();
    dWEN = 1'b0; ramstate = FREE;
    #1;
    check("t3_gap_ramWEN", ramWEN, 0);
    check("t3_gap_ramREN", ramREN, 0);
    check("t3_gap_iwait",  iwait,  1);
    step();
    ramstate = ACCESS; ramload = 32'h00001234;
    #1;
    check("t3_rd_ramREN",  ramREN,  1);
    check("t3_rd_ramaddr", ramaddr, 32'h200);
    check("t3_rd_iwait",   iwait,   0);
    check("t3_rd_iload",   iload,   32'h00001234);
    step();
    iREN = 1'b0; ramstate = FREE;

    // BUSY x3 then ERROR on a read, re-grant, complete
    step();
    dREN = 1'b1; daddr = 32'h300;
    step();
    for (int k = 0; k < 3; k++) begin
      ramstate = BUSY;
      #1;
      check("t4_busy_ramREN", ramREN, 1);
      check("t4_busy_dwait",  dwait,  1);
      step();
    end
    ramstate = ERROR;
    #1;
    check("t4_err_dwait", dwait, 1);
    check("t4_err_dload", dload, 0);
    step();
    ramstate = FREE;
    #1;
    check("t4_gap_ramREN", ramREN, 0);
    check("t4_gap_dwait",  dwait,  1);
    step();
    ramstate = ACCESS; ramload = 32'hCAFEF00D;
    #1;
    check("t4_acc_ramREN",  ramREN,  1);
    check("t4_acc_ramaddr", ramaddr, 32'h300);
    check("t4_acc_dwait",   dwait,   0);
    check("t4_acc_dload",   dload,   32'hCAFEF00D);
    step();
    dREN = 1'b0; ramstate = FREE;

    // Request dropped while granted: nothing reported, strobes gone next cycle
    step();
    dREN = 1'b1; daddr = 32'h400;
    step();
    dREN = 1'b0; ramstate = ACCESS; ramload = 32'h0000AAAA;
    #1;
    check("drop_ramREN", ramREN, 1);
    check("drop_dwait",  dwait,  1);
    check("drop_dload",  dload,  0);
    step();
    ramstate = FREE;
    #1;
    check("drop_next_ramREN", ramREN, 0);

    // dREN and dWEN together is a write
    step();
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h500; dstore = 32'h77;
    step();
    ramstate = ACCESS; ramload = 32'h99;
    #1;
    check("both_ramWEN",   ramWEN,   1);
    check("both_ramREN",   ramREN,   0);
    check("both_ramstore", ramstore, 32'h77);
    check("both_dwait",    dwait,    0);
    check("both_dload",    dload,    0);
    step();
    dREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
    #1;
    check("both_next_ramWEN", ramWEN, 0);

    // Async reset in the middle of a write
    step();
    dWEN = 1'b1; daddr = 32'h10; dstore = 32'h55;
    step();
    ramstate = BUSY;
    #1;
    check("t1_pre_ramWEN", ramWEN, 1);
    nRST = 1'b0;
    #1;
    check("t1_rst_ramWEN",  ramWEN,  0);
    check("t1_rst_iwait",   iwait,   1);
    check("t1_rst_dwait",   dwait,   1);
    check("t1_rst_ramaddr", ramaddr, 0);
    dWEN = 1'b0;
    step();
    nRST = 1'b1;
    step();
    #1;
    check("t1_post_ramWEN", ramWEN, 0);
    check("t1_post_ramREN", ramREN, 0);

    // Both sides held with RAM always ready: record order of the first 8 completions
    iREN = 1'b1; iaddr = 32'h700;
    dREN = 1'b1; daddr = 32'h600;
    ramstate = ACCESS; ramload = 32'h5A5A5A5A;
    comps = 0; fetches = 0; pat = '0;
    for (int c = 0; c < 20; c++) begin
      step();
      #1;
      if (!iwait) begin
        if (comps < 8) pat[comps] = 1'b1;
        fetches++;
        comps++;
      end else if (!dwait) begin
        comps++;
      end
    end
    check("t5_completions", comps, 10);
`ifdef ARB_FAIR_EN
    check("t5_order",   pat,     8'h10);
    check("t5_fetches", fetches, 2);
`else
    check("t5_order",   pat,     8'h00);
    check("t5_fetches", fetches, 0);
`endif
    iREN = 1'b0; dREN = 1'b0; ramstate = FREE;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
